match_logger: RTL and testbench

- Downstream consumer of the sequence detector's serial match output `z`.
- Counts detected matches and timestamps each one with its bit position in the input stream.
- Buffers the timestamps in a small first-word-fall-through FIFO with a valid/ready pop interface for the host or next stage.
- Sits directly after `seq_detector` and samples `z` on the same `clk`.

---
 rtl/match_logger_pkg.sv | 15 +
 rtl/match_logger_ts_fifo.sv | 63 ++++++
 rtl/match_logger.sv | 70 +++++++
 tb/tb_match_logger.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/match_logger_pkg.sv
// match_logger_pkg: shared defaults, pointer width helper, timestamp type, FIFO states
package match_logger_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int TS_W_DEF  = 8;
    localparam int DEPTH_DEF = 4;

    typedef logic [TS_W_DEF-1:0] ts_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fifo_st_e;

    // read/write pointers carry one extra bit so full and empty are distinguishable
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/match_logger_ts_fifo.sv
// ts_fifo: first-word-fall-through timestamp FIFO with drop reporting
// Ports: clk, reset (async high), clr (sync), push/push_data (write), pop (accept head),
//        head (oldest entry, 0 when empty), valid (non-empty), full, drop_pulse (push lost)
module ts_fifo
    import match_logger_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full,
    output logic         drop_pulse
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    fifo_st_e      r_state;
    logic          w_pop, w_push;
    logic [PW-1:0] w_cnt, w_cnt_nxt;

    // a pop frees a slot in the same edge, so a full FIFO still accepts a push alongside a pop
    always_comb begin
        w_pop      = pop && r_state != ST_EMPTY;
        w_push     = push && (r_state != ST_FULL || w_pop);
        w_cnt      = r_wr - r_rd;
        w_cnt_nxt  = w_cnt + PW'(w_push) - PW'(w_pop);
        drop_pulse = push && r_state == ST_FULL && !w_pop;
    end

    assign valid = r_state != ST_EMPTY;
    assign full  = r_state == ST_FULL;
    assign head  = valid ? r_mem[r_rd[AW-1:0]] : '0;

    always_ff @(posedge clk)
        if (w_push && !clr)
            r_mem[r_wr[AW-1:0]] <= push_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_state <= ST_EMPTY;
        end else if (clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_state <= ST_EMPTY;
        end else begin
            r_wr    <= r_wr + PW'(w_push);
            r_rd    <= r_rd + PW'(w_pop);
            r_state <= (w_cnt_nxt == '0) ? ST_EMPTY :
                       (w_cnt_nxt == PW'(DEPTH)) ? ST_FULL : ST_PARTIAL;
        end
    end
endmodule

// File: rtl/match_logger.sv
// match_logger: counts detector matches and queues their bit-position timestamps
// Ports: clk, reset (async high), z (match pulse), enable (advance/sample), clr (sync clear),
//        ts_ready/ts_valid/ts_data (FWFT pop), match_cnt, cnt_sat, fifo_full, overflow
module match_logger
    import match_logger_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z,
    input  logic             enable,
    input  logic             clr,
    input  logic             ts_ready,
    output logic             ts_valid,
    output logic [TS_W-1:0]  ts_data,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             fifo_full,
    output logic             overflow
);
    logic [TS_W-1:0]  r_pos;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat, r_ovf;
    logic             w_match, w_drop;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_match   = enable && z;
    assign w_cnt_nxt = (w_match && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;

    // the FIFO applies clr itself, so it drops a push/pop arriving with clr
    ts_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .push      (w_match),
        .push_data (r_pos),
        .pop       (ts_ready),
        .head      (ts_data),
        .valid     (ts_valid),
        .full      (fifo_full),
        .drop_pulse(w_drop)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_pos <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (enable)
                r_pos <= r_pos + 1'b1;
            r_cnt <= w_cnt_nxt;
            r_sat <= r_sat || (&w_cnt_nxt);
            r_ovf <= r_ovf || w_drop;
        end
    end

    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;
    assign overflow  = r_ovf;
endmodule

// File: tb/tb_match_logger.sv
// tb_match_logger: directed plus random stimulus against a queue-based reference model
module tb_match_logger;
    localparam int CNT_W = 3;
    localparam int TS_W  = 5;
    localparam int DEPTH = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int PMOD  = 1 << TS_W;

    logic             clk = 0;
    logic             reset = 1;
    logic             z = 0, enable = 0, clr = 0, ts_ready = 0;
    logic             ts_valid, cnt_sat, fifo_full, overflow;
    logic [TS_W-1:0]  ts_data;
    logic [CNT_W-1:0] match_cnt;

    int total = 0;
    int bad = 0;
    int q[$];
    int m_pos, m_cnt;
    bit m_sat, m_ovf;

    match_logger #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .z(z), .enable(enable), .clr(clr), .ts_ready(ts_ready),
        .ts_valid(ts_valid), .ts_data(ts_data), .match_cnt(match_cnt),
        .cnt_sat(cnt_sat), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        q.delete();
        m_pos = 0;
        m_cnt = 0;
        m_sat = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_edge();
        if (clr) begin
            m_clear();
            return;
        end
        if (ts_ready && q.size() > 0)
            void'(q.pop_front());
        if (enable && z) begin
            if (q.size() < DEPTH) q.push_back(m_pos);
            else m_ovf = 1;
            if (m_cnt < CMAX) m_cnt++;
            if (m_cnt == CMAX) m_sat = 1;
        end
        if (enable) m_pos = (m_pos + 1) % PMOD;
    endfunction

    task automatic check_all();
        check("valid", int'(ts_valid), int'(q.size() > 0));
        if (q.size() > 0) check("data", int'(ts_data), q[0]);
        check("cnt", int'(match_cnt), m_cnt);
        check("sat", int'(cnt_sat), int'(m_sat));
        check("full", int'(fifo_full), int'(q.size() == DEPTH));
        check("ovf", int'(overflow), int'(m_ovf));
    endtask

    task automatic step(input bit iz, input bit ien, input bit iclr, input bit irdy);
        z = iz;
        enable = ien;
        clr = iclr;
        ts_ready = irdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_data", int'(ts_data), 0);
        reset = 0;

        for (int i = 0; i < 10; i++) begin
            int p;
            p = m_pos;
            step(p == 3 || p == 7, 1, 0, 1);
            if (p == 3) check("p1_ts3", int'(ts_data), 3);
            if (p == 7) check("p1_ts7", int'(ts_data), 7);
        end
        check("p1_cnt", int'(match_cnt), 2);
        check("p1_ovf", int'(overflow), 0);

        step(0, 0, 1, 0);
        repeat (5) step(0, 1, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        check("p2_cnt", int'(match_cnt), 3);
        check("p2_full", int'(fifo_full), 0);
        for (int i = 5; i < 8; i++) begin
            check("p2_order", int'(ts_data), i);
            step(0, 0, 0, 1);
        end
        check("p2_empty", int'(ts_valid), 0);

        step(0, 0, 1, 0);
        repeat (6) step(1, 1, 0, 0);
        check("p3_full", int'(fifo_full), 1);
        check("p3_ovf", int'(overflow), 1);
        check("p3_cnt", int'(match_cnt), 6);
        for (int i = 0; i < 4; i++) begin
            check("p3_order", int'(ts_data), i);
            step(0, 0, 0, 1);
        end
        check("p3_empty", int'(ts_valid), 0);

        step(0, 0, 1, 0);
        repeat (4) step(1, 1, 0, 0);
        repeat (5) step(0, 1, 0, 0);
        step(1, 1, 0, 1);
        check("p4_ovf", int'(overflow), 0);
        check("p4_full", int'(fifo_full), 1);
        check("p4_head", int'(ts_data), 1);
        repeat (3) step(0, 0, 0, 1);
        check("p4_tail", int'(ts_data), 9);
        step(0, 0, 0, 1);

        step(0, 0, 1, 0);
        repeat (9) step(1, 1, 0, 1);
        check("sat_cnt", int'(match_cnt), CMAX);
        check("sat_flag", int'(cnt_sat), 1);

        step(0, 0, 1, 0);
        repeat (PMOD + 1) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("wrap_ts", int'(ts_data), 1);

        repeat (2) step(1, 1, 0, 0);
        step(1, 1, 1, 1);
        check("clr_valid", int'(ts_valid), 0);
        check("clr_cnt", int'(match_cnt), 0);

        repeat (2) step(1, 1, 0, 0);
        #3;
        reset = 1;
        #1;
        check("async_valid", int'(ts_valid), 0);
        check("async_cnt", int'(match_cnt), 0);
        m_clear();
        @(posedge clk);
        #1;
        reset = 0;
        check_all();

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
